// File: rtl/synth_pkg.sv
// Shared types and constants for the sample mixer that feeds the PWM output stage.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } mix_state_t;

  localparam int SAMPLE_W = 8;
  localparam int VOL_W = 4;
  localparam logic [3:0] VOL_UNITY = 4'd15;

endpackage

// File: rtl/mix_scaler.sv
// Normalises an accumulated voice sum by the active-voice count, then applies
// the master volume, where (volume + 1) / 16 gives unity at full scale.
module mix_scaler
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W = 8,
  parameter int VOL_W = 4,
  parameter int ACC_W = SAMPLE_W + $clog2(NUM_VOICES),
  parameter int CNT_W = $clog2(NUM_VOICES + 1)
) (
  input  logic [ACC_W-1:0]    acc,
  input  logic [CNT_W-1:0]    active_cnt,
  input  logic [VOL_W-1:0]    volume,
  output logic [SAMPLE_W-1:0] scaled
);

  localparam int PROD_W = SAMPLE_W + VOL_W + 1;
  localparam logic [ACC_W-1:0] NORM_MAX = ACC_W'((1 << SAMPLE_W) - 1);

  logic [1:0]          shift;
  logic [ACC_W-1:0]    norm_wide;
  logic [SAMPLE_W-1:0] norm;
  logic [VOL_W:0]      vol_plus_one;
  logic [PROD_W-1:0]   product;

  // Shift is ceil(log2(active_cnt)), so the average never exceeds full scale.
  always_comb begin
    shift = 2'd0;
    if (int'(active_cnt) > 4) begin
      shift = 2'd3;
    end else if (int'(active_cnt) > 2) begin
      shift = 2'd2;
    end else if (int'(active_cnt) > 1) begin
      shift = 2'd1;
    end
  end

  always_comb begin
    norm_wide    = acc >> shift;
    norm         = (norm_wide > NORM_MAX) ? {SAMPLE_W{1'b1}} : norm_wide[SAMPLE_W-1:0];
    vol_plus_one = {1'b0, volume} + {{VOL_W{1'b0}}, 1'b1};
    product      = PROD_W'(norm) * PROD_W'(vol_plus_one);
    scaled       = (active_cnt == '0) ? '0 : product[VOL_W +: SAMPLE_W];
  end

endmodule

// File: rtl/sample_mixer.sv
// Serial voice mixer: on each strobe it snapshots the voices, sums them one per
// cycle, normalises, applies volume and presents a held sample to the PWM.
module sample_mixer
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W = 8,
  parameter int VOL_W = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_strobe,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  input  logic [NUM_VOICES-1:0]          voice_en,
  input  logic [VOL_W-1:0]               volume,
  output logic [SAMPLE_W-1:0]            mixed_sample,
  output logic                           mixed_valid,
  output logic                           busy,
  output logic                           overrun
);

  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int CNT_W = $clog2(NUM_VOICES + 1);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  mix_state_t                     state_q, state_d;
  logic [NUM_VOICES*SAMPLE_W-1:0] sample_snap_q, sample_snap_d;
  logic [NUM_VOICES-1:0]          en_snap_q, en_snap_d;
  logic [VOL_W-1:0]               vol_snap_q, vol_snap_d;
  logic [ACC_W-1:0]               acc_q, acc_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]            scaled_q, scaled_d;
  logic [SAMPLE_W-1:0]            mixed_sample_q, mixed_sample_d;
  logic                           mixed_valid_q, mixed_valid_d;
  logic                           overrun_q, overrun_d;

  logic [SAMPLE_W-1:0] cur_sample;
  logic [SAMPLE_W-1:0] scaler_out;

  assign cur_sample = sample_snap_q[SAMPLE_W*int'(idx_q) +: SAMPLE_W];

  mix_scaler #(
    .NUM_VOICES(NUM_VOICES),
    .SAMPLE_W  (SAMPLE_W),
    .VOL_W     (VOL_W),
    .ACC_W     (ACC_W),
    .CNT_W     (CNT_W)
  ) u_scaler (
    .acc       (acc_q),
    .active_cnt(cnt_q),
    .volume    (vol_snap_q),
    .scaled    (scaler_out)
  );

  always_comb begin
    state_d        = state_q;
    sample_snap_d  = sample_snap_q;
    en_snap_d      = en_snap_q;
    vol_snap_d     = vol_snap_q;
    acc_d          = acc_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    scaled_d       = scaled_q;
    mixed_sample_d = mixed_sample_q;
    mixed_valid_d  = 1'b0;
    overrun_d      = 1'b0;

    // Strobes that arrive mid-mix are dropped; flag them so the PWM side can see jitter.
    if (sample_strobe && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (sample_strobe) begin
          sample_snap_d = voice_sample;
          en_snap_d     = voice_en;
          vol_snap_d    = volume;
          acc_d         = '0;
          idx_d         = '0;
          cnt_d         = '0;
          state_d       = ACCUM;
        end
      end
      ACCUM: begin
        if (en_snap_q[idx_q]) begin
          acc_d = acc_q + ACC_W'(cur_sample);
          cnt_d = cnt_q + CNT_W'(1);
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = SCALE;
        end
      end
      SCALE: begin
        scaled_d = scaler_out;
        state_d  = OUT;
      end
      OUT: begin
        mixed_sample_d = scaled_q;
        mixed_valid_d  = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      sample_snap_q  <= '0;
      en_snap_q      <= '0;
      vol_snap_q     <= '0;
      acc_q          <= '0;
      idx_q          <= '0;
      cnt_q          <= '0;
      scaled_q       <= '0;
      mixed_sample_q <= '0;
      mixed_valid_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sample_snap_q  <= sample_snap_d;
      en_snap_q      <= en_snap_d;
      vol_snap_q     <= vol_snap_d;
      acc_q          <= acc_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      scaled_q       <= scaled_d;
      mixed_sample_q <= mixed_sample_d;
      mixed_valid_q  <= mixed_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign mixed_sample = mixed_sample_q;
  assign mixed_valid  = mixed_valid_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);

endmodule
